inst_type_encoder: RTL and testbench



---
 rtl/inst_type_encoder.sv | 155 +++++++++++++++
 tb/tb_inst_type_encoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_type_encoder.sv
// inst_type_encoder: assembles an RV32I instruction word from a type index
// and operand fields, strobes it out, then shows it on active-low LEDs one
// nibble at a time, most significant nibble first.
//
// Handshake: a request is accepted on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in IDLE, and in_valid is
// ignored at any other time (nothing is queued).
module inst_type_encoder #(
  parameter int DELAY_COUNT = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  type_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        err,
  output logic [3:0]  led,
  output logic [1:0]  state_dbg
);

  localparam int CW = (DELAY_COUNT > 1) ? $clog2(DELAY_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_COUNT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENCODE = 2'd1;
  localparam logic [1:0] S_SHOW   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;

  // Request fields captured on the accept edge
  logic [3:0]  type_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic [31:0] imm_q;

  logic [31:0] enc;
  logic        enc_legal;

  assign state_dbg = state;

  // Capture the request only when it is accepted so later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q <= 4'd0;
      rd_q   <= 5'd0;
      rs1_q  <= 5'd0;
      rs2_q  <= 5'd0;
      f3_q   <= 3'd0;
      f7_q   <= 7'd0;
      imm_q  <= 32'd0;
    end else if (state == S_IDLE && in_valid) begin
      type_q <= type_sel;
      rd_q   <= rd;
      rs1_q  <= rs1;
      rs2_q  <= rs2;
      f3_q   <= funct3;
      f7_q   <= funct7;
      imm_q  <= imm;
    end
  end

  // Instruction word assembly from the captured fields
  always_comb begin
    enc       = 32'd0;
    enc_legal = 1'b1;
    case (type_q)
      4'd0: enc = {f7_q, rs2_q, rs1_q, f3_q, rd_q, 7'b0110011};
      4'd1: enc = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0010011};
      4'd2: enc = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'b0100011};
      4'd3: enc = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
      4'd4: enc = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                   imm_q[4:1], imm_q[11], 7'b1100011};
      4'd5: enc = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                   rd_q, 7'b1101111};
      // JALR always carries funct3 = 000
      4'd6: enc = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b1100111};
      4'd7: enc = {imm_q[31:12], rd_q, 7'b0110111};
      4'd8: enc = {imm_q[31:12], rd_q, 7'b0010111};
      default: enc_legal = 1'b0;
    endcase
  end

  // Control FSM: accept, encode for one cycle, then walk the nibbles on the LEDs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      inst       <= 32'd0;
      inst_valid <= 1'b0;
      err        <= 1'b0;
      led        <= 4'hF;
      cnt        <= '0;
      idx        <= 3'd0;
    end else begin
      inst_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state    <= S_ENCODE;
            in_ready <= 1'b0;
          end
        end
        S_ENCODE: begin
          if (enc_legal) begin
            inst       <= enc;
            inst_valid <= 1'b1;
            state      <= S_SHOW;
            idx        <= 3'd7;
            cnt        <= '0;
            led        <= ~enc[31:28];
          end else begin
            err      <= 1'b1;
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == 3'd0) begin
              state    <= S_IDLE;
              in_ready <= 1'b1;
              led      <= 4'hF;
            end else begin
              idx <= idx - 3'd1;
              led <= ~inst[{idx - 3'd1, 2'b00} +: 4];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          led      <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_type_encoder.sv
// Bench for inst_type_encoder: directed cases with literal expectations plus
// randomized requests compared every cycle against a timeline model.
module tb_inst_type_encoder;

  localparam int DC = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  type_sel;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [31:0] inst;
  logic        inst_valid;
  logic        err;
  logic [3:0]  led;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  inst_type_encoder #(.DELAY_COUNT(DC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .type_sel(type_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .inst(inst), .inst_valid(inst_valid),
    .err(err), .led(led), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction word built by placing each field at its bit offset.
  function automatic logic [31:0] model_encode(input logic [3:0] t, input logic [4:0] f_rd,
      input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    logic [31:0] base;
    base = (32'(f_rs1) << 15) | (32'(f3) << 12);
    case (t)
      4'd0: w = (32'(f7) << 25) | (32'(f_rs2) << 20) | base | (32'(f_rd) << 7) | 32'h33;
      4'd1: w = ((im & 32'hFFF) << 20) | base | (32'(f_rd) << 7) | 32'h13;
      4'd2: w = (((im >> 5) & 32'h7F) << 25) | (32'(f_rs2) << 20) | base
              | ((im & 32'h1F) << 7) | 32'h23;
      4'd3: w = ((im & 32'hFFF) << 20) | base | (32'(f_rd) << 7) | 32'h03;
      4'd4: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
              | (32'(f_rs2) << 20) | base | (((im >> 1) & 32'hF) << 8)
              | (((im >> 11) & 32'h1) << 7) | 32'h63;
      4'd5: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
              | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
              | (32'(f_rd) << 7) | 32'h6F;
      4'd6: w = ((im & 32'hFFF) << 20) | (32'(f_rs1) << 15) | (32'(f_rd) << 7) | 32'h67;
      4'd7: w = (im & 32'hFFFFF000) | (32'(f_rd) << 7) | 32'h37;
      4'd8: w = (im & 32'hFFFFF000) | (32'(f_rd) << 7) | 32'h17;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // m_t counts cycles since the accept edge (-1 when no request in flight)
  int          m_t;
  logic        m_legal;
  logic [31:0] m_pend;
  logic [31:0] m_inst;
  logic [31:0] exp_q[$];

  function automatic bit m_idle();
    return (m_t < 0) || (!m_legal && m_t >= 1) || (m_legal && m_t >= 8 * DC + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t     <= -1;
      m_legal <= 1'b0;
      m_pend  <= 32'h0;
      m_inst  <= 32'h0;
      exp_q.delete();
    end else if (m_idle()) begin
      if (in_valid) begin
        m_t     <= 0;
        m_legal <= (type_sel < 4'd9);
        m_pend  <= model_encode(type_sel, rd, rs1, rs2, funct3, funct7, imm);
      end else begin
        m_t <= -1;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t == 0 && m_legal) begin
        m_inst <= m_pend;
        exp_q.push_back(m_pend);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0]  exp_led;
      logic [31:0] sb_exp;
      int          nib;
      if (m_legal && m_t >= 1 && m_t <= 8 * DC) begin
        nib     = 7 - (m_t - 1) / DC;
        exp_led = ~4'((m_inst >> (4 * nib)) & 32'hF);
      end else begin
        exp_led = 4'hF;
      end
      check("in_ready", 32'(in_ready), 32'(m_idle()));
      check("inst_valid", 32'(inst_valid), 32'(m_legal && m_t == 1));
      check("err", 32'(err), 32'(!m_legal && m_t == 1));
      check("led", 32'(led), 32'(exp_led));
      check("inst", inst, m_inst);
      check("strobe_exclusive", 32'(inst_valid & err), 32'h0);
      if (inst_valid) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'h1, 32'h0);
        end else begin
          sb_exp = exp_q.pop_front();
          check("scoreboard_inst", inst, sb_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble();
    type_sel = 4'($urandom_range(0, 15));
    rd       = 5'($urandom);
    rs1      = 5'($urandom);
    rs2      = 5'($urandom);
    funct3   = 3'($urandom);
    funct7   = 7'($urandom);
    imm      = $urandom;
  endtask

  // Returns #1 after the accept edge, i.e. inside the cycle after the accept.
  task automatic send(input logic [3:0] t, input logic [4:0] f_rd, input logic [4:0] f_rs1,
      input logic [4:0] f_rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] im);
    int n;
    @(negedge clk);
    type_sel = t; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 8 * DC + 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8 * DC + 10) check("send_timeout", 32'h1, 32'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 8 * DC + 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8 * DC + 10) check("idle_timeout", 32'h1, 32'h0);
  endtask

  // Sends a request and checks the encoded word two edges after the accept.
  task automatic send_check(input string name, input logic [3:0] t, input logic [4:0] f_rd,
      input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im, input logic [31:0] exp_word);
    send(t, f_rd, f_rs1, f_rs2, f3, f7, im);
    @(negedge clk);
    @(negedge clk);
    check({name, "_valid"}, 32'(inst_valid), 32'h1);
    check(name, inst, exp_word);
    wait_idle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [3:0] r_seq [8];

  initial begin
    r_seq[0] = 4'b1011; r_seq[1] = 4'b1111; r_seq[2] = 4'b1100; r_seq[3] = 4'b1110;
    r_seq[4] = 4'b1111; r_seq[5] = 4'b1111; r_seq[6] = 4'b0100; r_seq[7] = 4'b1100;

    rst_n = 1'b0;
    in_valid = 1'b0;
    type_sel = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset values
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_led", 32'(led), 32'hF);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Hand-computed words pin the model encoder
    check("pin_r_sub", model_encode(4'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'h0), 32'h403100B3);
    check("pin_addi", model_encode(4'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF), 32'hFFF00293);
    check("pin_beq", model_encode(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h8), 32'h00208463);
    check("pin_jal", model_encode(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800), 32'h001000EF);

    // R-type sub with full LED walk; in_valid pulses during SHOW are ignored
    send(4'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("r_sub_valid", 32'(inst_valid), 32'h1);
    check("r_sub_inst", inst, 32'h403100B3);
    for (int k = 0; k < 8 * DC; k++) begin
      check("r_sub_led", 32'(led), 32'(r_seq[k / DC]));
      if (k == 10) begin
        type_sel = 4'd1;
        in_valid = 1'b1;
      end
      if (k == 14) in_valid = 1'b0;
      @(negedge clk);
    end
    check("r_sub_led_off", 32'(led), 32'hF);
    check("r_sub_ready", 32'(in_ready), 32'h1);
    check("r_sub_inst_kept", inst, 32'h403100B3);

    send_check("addi", 4'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00293);
    send_check("beq", 4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h8, 32'h00208463);
    send_check("jal", 4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h001000EF);

    // Illegal type
    send(4'd9, 5'd3, 5'd3, 5'd3, 3'd1, 7'd1, 32'h1234);
    @(negedge clk);
    check("illegal_t0_err", 32'(err), 32'h0);
    check("illegal_t0_led", 32'(led), 32'hF);
    @(negedge clk);
    check("illegal_err", 32'(err), 32'h1);
    check("illegal_inst_valid", 32'(inst_valid), 32'h0);
    check("illegal_inst_hold", inst, 32'h001000EF);
    check("illegal_ready", 32'(in_ready), 32'h1);
    check("illegal_led", 32'(led), 32'hF);

    // Reset while nibble index 5 is on display
    send(4'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'h0);
    repeat (2 + 2 * DC) @(negedge clk);
    check("mid_show_led_idx5", 32'(led), 32'b1100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'hF);
    check("async_rst_ready", 32'(in_ready), 32'h1);
    check("async_rst_inst", inst, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_check("post_rst_addi", 4'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00293);

    // Randomized requests, roughly a quarter illegal, random gaps
    for (int i = 0; i < 40; i++) begin
      logic [3:0] t;
      t = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      send(t, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
